// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback wins, async results bypass or queue.
// Zero-cycle write path; lu_ack drops when the queue is full, stall_req on full queue or starved head.
module rf_wport_arb #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wb_wreg,
    input  logic [4:0]  i_wb_wd,
    input  logic [31:0] i_wb_wdata,
    input  logic        i_lu_req,
    input  logic [4:0]  i_lu_wd,
    input  logic [31:0] i_lu_wdata,
    output logic        o_lu_ack,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic [31:0] o_pend_mask,
    output logic        o_stall_req
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;

    logic w_wb_act;
    logic w_lu_null;
    logic w_empty;
    logic w_head_vld;
    logic w_pop;
    logic w_bypass;
    logic w_ack;
    logic w_enq;

    always_comb begin
        w_wb_act   = i_wb_wreg && (i_wb_wd != 5'd0);
        w_lu_null  = (i_lu_wd == 5'd0);
        w_empty    = (r_count == '0);
        w_head_vld = !w_empty && r_vld[r_rd_ptr];
        // A killed head leaves without a write even while the pipeline owns the port.
        w_pop      = !w_empty && (!r_vld[r_rd_ptr] || !w_wb_act);
        w_bypass   = w_empty && i_lu_req && !w_lu_null && !w_wb_act;
        w_ack      = i_lu_req && (r_count < CW'(DEPTH));
        w_enq      = w_ack && !w_bypass && !w_lu_null && !(w_wb_act && (i_lu_wd == i_wb_wd));
    end

    always_comb begin
        o_lu_ack    = 1'b0;
        o_rf_we     = 1'b0;
        o_rf_waddr  = 5'd0;
        o_rf_wdata  = 32'd0;
        o_pend_mask = 32'd0;
        o_stall_req = 1'b0;
        if (!rst) begin
            o_lu_ack = w_ack;
            if (w_wb_act) begin
                o_rf_we    = 1'b1;
                o_rf_waddr = i_wb_wd;
                o_rf_wdata = i_wb_wdata;
            end else if (w_head_vld) begin
                o_rf_we    = 1'b1;
                o_rf_waddr = r_addr[r_rd_ptr];
                o_rf_wdata = r_data[r_rd_ptr];
            end else if (w_bypass) begin
                o_rf_we    = 1'b1;
                o_rf_waddr = i_lu_wd;
                o_rf_wdata = i_lu_wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i]) o_pend_mask[r_addr[i]] = 1'b1;
            end
            o_stall_req = (r_count == CW'(DEPTH)) || (r_starve == SW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            // Pipeline write is younger than anything queued: drop stale entries to the same register.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wb_act && r_vld[i] && (r_addr[i] == i_wb_wd)) r_vld[i] <= 1'b0;
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + PW'(1);
            end
            if (w_enq) begin
                r_vld[r_wr_ptr]  <= 1'b1;
                r_addr[r_wr_ptr] <= i_lu_wd;
                r_data[r_wr_ptr] <= i_lu_wdata;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_pop);
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (w_head_vld && w_wb_act && (r_starve != SW'(STARVE_LIMIT))) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb: bypass, collision, kill, full, starvation, reset, r0.
module tb_rf_wport_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wb_wreg;
    logic [4:0]  i_wb_wd;
    logic [31:0] i_wb_wdata;
    logic        i_lu_req;
    logic [4:0]  i_lu_wd;
    logic [31:0] i_lu_wdata;
    logic        o_lu_ack;
    logic        o_rf_we;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic [31:0] o_pend_mask;
    logic        o_stall_req;

    int n_pass  = 0;
    int n_total = 0;
    int r0_writes = 0;
    logic [31:0] rf_m [32];

    rf_wport_arb #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wb_wreg   (i_wb_wreg),
        .i_wb_wd     (i_wb_wd),
        .i_wb_wdata  (i_wb_wdata),
        .i_lu_req    (i_lu_req),
        .i_lu_wd     (i_lu_wd),
        .i_lu_wdata  (i_lu_wdata),
        .o_lu_ack    (o_lu_ack),
        .o_rf_we     (o_rf_we),
        .o_rf_waddr  (o_rf_waddr),
        .o_rf_wdata  (o_rf_wdata),
        .o_pend_mask (o_pend_mask),
        .o_stall_req (o_stall_req)
    );

    always #5 clk = ~clk;

    // Register-file image built from the write port.
    always @(posedge clk) begin
        if (o_rf_we) begin
            rf_m[o_rf_waddr] <= o_rf_wdata;
            if (o_rf_waddr == 5'd0) r0_writes <= r0_writes + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; i_wb_wreg = 1'b0; i_wb_wd = '0; i_wb_wdata = '0;
        i_lu_req = 1'b1; i_lu_wd = 5'd5; i_lu_wdata = 32'h5;
        cyc(); cyc();
        settle();
        chk("rst_ack", {31'd0, o_lu_ack}, 32'd0);
        chk("rst_we", {31'd0, o_rf_we}, 32'd0);
        chk("rst_pend", o_pend_mask, 32'd0);
        chk("rst_stall", {31'd0, o_stall_req}, 32'd0);
        rst = 1'b0; i_lu_req = 1'b0;
        cyc(); settle();
        chk("idle_we", {31'd0, o_rf_we}, 32'd0);
        chk("idle_pend", o_pend_mask, 32'd0);

        // Bypass
        i_lu_req = 1'b1; i_lu_wd = 5'd7; i_lu_wdata = 32'hDEADBEEF;
        settle();
        chk("byp_we", {31'd0, o_rf_we}, 32'd1);
        chk("byp_addr", {27'd0, o_rf_waddr}, 32'd7);
        chk("byp_data", o_rf_wdata, 32'hDEADBEEF);
        chk("byp_ack", {31'd0, o_lu_ack}, 32'd1);
        cyc(); i_lu_req = 1'b0; settle();
        chk("byp_pend", o_pend_mask, 32'd0);
        chk("byp_rf7", rf_m[7], 32'hDEADBEEF);

        // Collision: pipeline wins, r9 parked
        i_wb_wreg = 1'b1; i_wb_wd = 5'd3; i_wb_wdata = 32'h11;
        i_lu_req = 1'b1; i_lu_wd = 5'd9; i_lu_wdata = 32'h22;
        settle();
        chk("col_addr", {27'd0, o_rf_waddr}, 32'd3);
        chk("col_data", o_rf_wdata, 32'h11);
        chk("col_ack", {31'd0, o_lu_ack}, 32'd1);
        cyc(); i_wb_wreg = 1'b0; i_lu_req = 1'b0; settle();
        chk("col_pend", o_pend_mask, 32'h200);
        chk("col_drain_addr", {27'd0, o_rf_waddr}, 32'd9);
        chk("col_drain_data", o_rf_wdata, 32'h22);
        cyc(); settle();
        chk("col_pend0", o_pend_mask, 32'd0);
        chk("col_rf9", rf_m[9], 32'h22);

        // Kill: queue r9, then pipeline writes r9 while r10 queues
        i_wb_wreg = 1'b1; i_wb_wd = 5'd3; i_wb_wdata = 32'h12;
        i_lu_req = 1'b1; i_lu_wd = 5'd9; i_lu_wdata = 32'h33;
        cyc();
        i_wb_wd = 5'd9; i_wb_wdata = 32'h55;
        i_lu_wd = 5'd10; i_lu_wdata = 32'h44;
        settle();
        chk("kill_wb_addr", {27'd0, o_rf_waddr}, 32'd9);
        chk("kill_pend_pre", o_pend_mask, 32'h200);
        cyc(); i_wb_wreg = 1'b0; i_lu_req = 1'b0; settle();
        chk("kill_pend_post", o_pend_mask, 32'h400);
        chk("kill_head_nowrite", {31'd0, o_rf_we}, 32'd0);
        cyc(); settle();
        chk("kill_next_addr", {27'd0, o_rf_waddr}, 32'd10);
        chk("kill_next_we", {31'd0, o_rf_we}, 32'd1);
        cyc(); cyc(); settle();
        chk("kill_pend0", o_pend_mask, 32'd0);
        chk("kill_rf9", rf_m[9], 32'h55);
        chk("kill_rf10", rf_m[10], 32'h44);

        // Full / backpressure
        i_wb_wreg = 1'b1; i_wb_wd = 5'd1; i_wb_wdata = 32'h1;
        i_lu_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_lu_wd = 5'(11 + i); i_lu_wdata = 32'h100 + 32'(i);
            settle();
            chk("full_ack", {31'd0, o_lu_ack}, 32'd1);
            cyc();
        end
        i_lu_wd = 5'd15; i_lu_wdata = 32'h104;
        settle();
        chk("full_ack5", {31'd0, o_lu_ack}, 32'd0);
        chk("full_stall", {31'd0, o_stall_req}, 32'd1);
        chk("full_pend", o_pend_mask, 32'h7800);
        cyc(); settle();
        chk("full_ack5_hold", {31'd0, o_lu_ack}, 32'd0);
        i_wb_wreg = 1'b0; settle();
        chk("drain_ack_same", {31'd0, o_lu_ack}, 32'd0);
        chk("drain_addr", {27'd0, o_rf_waddr}, 32'd11);
        cyc(); settle();
        chk("drain_ack_next", {31'd0, o_lu_ack}, 32'd1);
        chk("drain_addr2", {27'd0, o_rf_waddr}, 32'd12);
        cyc(); i_lu_req = 1'b0;
        cyc(); cyc(); cyc(); settle();
        chk("drain_pend0", o_pend_mask, 32'd0);
        chk("drain_stall0", {31'd0, o_stall_req}, 32'd0);
        chk("drain_rf15", rf_m[15], 32'h104);

        // Starvation
        i_wb_wreg = 1'b1; i_wb_wd = 5'd1;
        i_lu_req = 1'b1; i_lu_wd = 5'd20; i_lu_wdata = 32'h200;
        cyc(); i_lu_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("starve_lo", {31'd0, o_stall_req}, 32'd0);
            cyc();
        end
        settle();
        chk("starve_hi", {31'd0, o_stall_req}, 32'd1);
        i_wb_wreg = 1'b0; settle();
        chk("starve_hold", {31'd0, o_stall_req}, 32'd1);
        chk("starve_drain_addr", {27'd0, o_rf_waddr}, 32'd20);
        cyc(); settle();
        chk("starve_clear", {31'd0, o_stall_req}, 32'd0);
        chk("starve_pend0", o_pend_mask, 32'd0);

        // Reset mid-operation with three queued entries
        i_wb_wreg = 1'b1; i_wb_wd = 5'd1; i_lu_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_lu_wd = 5'(21 + i); i_lu_wdata = 32'h300 + 32'(i);
            cyc();
        end
        i_lu_req = 1'b0; settle();
        chk("mid_pend", o_pend_mask, 32'h00E00000);
        rst = 1'b1; settle();
        chk("mid_rst_we", {31'd0, o_rf_we}, 32'd0);
        cyc(); rst = 1'b0; i_wb_wreg = 1'b0; settle();
        chk("post_rst_pend", o_pend_mask, 32'd0);
        chk("post_rst_we", {31'd0, o_rf_we}, 32'd0);
        chk("post_rst_stall", {31'd0, o_stall_req}, 32'd0);

        // r0 result: acked, discarded
        i_lu_req = 1'b1; i_lu_wd = 5'd0; i_lu_wdata = 32'hBAD;
        settle();
        chk("r0_ack", {31'd0, o_lu_ack}, 32'd1);
        chk("r0_we", {31'd0, o_rf_we}, 32'd0);
        cyc(); i_lu_req = 1'b0; settle();
        chk("r0_pend", o_pend_mask, 32'd0);
        chk("r0_we_after", {31'd0, o_rf_we}, 32'd0);
        cyc();
        chk("r0_writes", 32'(r0_writes), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
